tel_readout_ctrl: RTL and testbench

Sequencer that turns a telemetry request into one complete monitor frame. It drives the trigger-monitor readout port (`rd`/address), which snapshots all monitor registers on the first read of address 0x19. It then walks the address space 0x19–0x3B and streams a header word, the data words and an optional checksum over a 16-bit valid/ready interface to the telemetry packer. It sits between the housekeeping command decoder (request source) and the trigger-monitor data block.

---
 rtl/tel_pkg.sv | 19 +
 rtl/tel_chksum_acc.sv | 30 +++
 rtl/tel_readout_ctrl.sv | 149 ++++++++++++++
 tb/tb_tel_readout_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tel_pkg.sv
// Shared types and default constants for the telemetry readout sequencer.
// Optional checksum word is enabled by defining TEL_CHKSUM_EN.
package tel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_CHK,
        ST_DONE
    } tel_state_t;

    localparam logic [7:0]  TEL_FIRST_ADDR = 8'h19;
    localparam logic [7:0]  TEL_LAST_ADDR  = 8'h3B;
    localparam logic [15:0] TEL_HEAD_WORD  = 16'h1ACF;

endpackage

// File: rtl/tel_chksum_acc.sv
// 16-bit additive accumulator with clear and enable; clear wins over accumulate.
module tel_chksum_acc (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clr_in,
    input  logic        en_in,
    input  logic [15:0] din_in,
    output logic [15:0] sum_out
);

    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_in)
            sum_d = 16'h0000;
        else if (en_in)
            sum_d = sum_q + din_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            sum_q <= 16'h0000;
        else
            sum_q <= sum_d;
    end

    assign sum_out = sum_q;

endmodule

// File: rtl/tel_readout_ctrl.sv
// Reads the trigger-monitor address range once per request and streams header,
// data words and (with TEL_CHKSUM_EN defined) a checksum word over valid/ready.
module tel_readout_ctrl
    import tel_pkg::*;
#(
    parameter logic [7:0]  FIRST_ADDR = TEL_FIRST_ADDR,
    parameter logic [7:0]  LAST_ADDR  = TEL_LAST_ADDR,
    parameter logic [15:0] HEAD_WORD  = TEL_HEAD_WORD
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tel_req_in,
    input  logic        abort_in,
    output logic        mon_rd_out,
    output logic [7:0]  mon_addr_out,
    input  logic [15:0] mon_data_in,
    output logic [15:0] tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        req_lost_out
);

    tel_state_t  state_q, state_d;
    logic [7:0]  cur_addr_q, cur_addr_d;
    logic [15:0] word_q, word_d;
    logic        req_lost_q, req_lost_d;

    logic handshake;
    logic accept;
    logic aborting;

    assign handshake = tx_valid_out & tx_ready_in;
    assign accept    = (state_q == ST_IDLE) & tel_req_in;
    assign aborting  = (state_q != ST_IDLE) & abort_in;

`ifdef TEL_CHKSUM_EN
    logic [15:0] chksum;

    tel_chksum_acc u_chksum (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  (accept),
        .en_in   (state_q == ST_LATCH),
        .din_in  (mon_data_in),
        .sum_out (chksum)
    );
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= FIRST_ADDR;
            word_q     <= 16'h0000;
            req_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            word_q     <= word_d;
            req_lost_q <= req_lost_d;
        end
    end

    // Abort overrides any handshake seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (tel_req_in) state_d = ST_HEAD;
                ST_HEAD:  if (handshake)  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_LATCH;
                ST_LATCH: state_d = ST_SEND;
                ST_SEND: begin
                    if (handshake) begin
                        if (cur_addr_q == LAST_ADDR)
`ifdef TEL_CHKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
`endif
                        else
                            state_d = ST_FETCH;
                    end
                end
`ifdef TEL_CHKSUM_EN
                ST_CHK:   if (handshake) state_d = ST_DONE;
`endif
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_addr_d = cur_addr_q;
        word_d     = word_q;
        req_lost_d = req_lost_q;
        if (accept)
            cur_addr_d = FIRST_ADDR;
        else if ((state_q == ST_SEND) && handshake && !abort_in && (cur_addr_q != LAST_ADDR))
            cur_addr_d = cur_addr_q + 8'd1;
        if (state_q == ST_LATCH)
            word_d = mon_data_in;
        if (accept)
            req_lost_d = 1'b0;
        else if (tel_req_in)
            req_lost_d = 1'b1;
    end

    // rd stays high from HEAD through SEND so the snapshot edge happens exactly once.
    always_comb begin
        tx_data_out  = 16'h0000;
        tx_valid_out = 1'b0;
        mon_rd_out   = 1'b0;
        mon_addr_out = FIRST_ADDR;
        done_out     = 1'b0;
        busy_out     = (state_q != ST_IDLE);
        req_lost_out = req_lost_q;
        case (state_q)
            ST_HEAD: begin
                tx_data_out  = HEAD_WORD;
                tx_valid_out = 1'b1;
                mon_rd_out   = 1'b1;
            end
            ST_FETCH, ST_LATCH: begin
                mon_rd_out   = 1'b1;
                mon_addr_out = cur_addr_q;
            end
            ST_SEND: begin
                tx_data_out  = word_q;
                tx_valid_out = 1'b1;
                mon_rd_out   = 1'b1;
                mon_addr_out = cur_addr_q;
            end
`ifdef TEL_CHKSUM_EN
            ST_CHK: begin
                tx_data_out  = chksum;
                tx_valid_out = 1'b1;
            end
`endif
            ST_DONE: done_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tel_readout_ctrl.sv
// Directed bench for tel_readout_ctrl; follows TEL_CHKSUM_EN to pick frame length
// and completion timing.
module tb_tel_readout_ctrl;

`ifdef TEL_CHKSUM_EN
    localparam int N_WORDS = 37;
    localparam int DONE_K  = 107;
`else
    localparam int N_WORDS = 36;
    localparam int DONE_K  = 106;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tel_req, abort, tx_ready;
    logic        mon_rd;
    logic [7:0]  mon_addr;
    logic [15:0] mon_data;
    logic [15:0] tx_data;
    logic        tx_valid, busy, done, req_lost;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    int stall_viol = 0;
    logic rd_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [15:0] stall_data = 16'h0;
    logic [15:0] got[$];

    int e0, base, rbase, k, busy_n;
    bit found;
    int done_seen;

    always #10 clk = ~clk;

    tel_readout_ctrl dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .tel_req_in   (tel_req),
        .abort_in     (abort),
        .mon_rd_out   (mon_rd),
        .mon_addr_out (mon_addr),
        .mon_data_in  (mon_data),
        .tx_data_out  (tx_data),
        .tx_valid_out (tx_valid),
        .tx_ready_in  (tx_ready),
        .busy_out     (busy),
        .done_out     (done),
        .req_lost_out (req_lost)
    );

    // Monitor block model: output register loads addr*0x0101 while rd is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_rd)
            mon_data <= {mon_addr, mon_addr};
        if (mon_rd && !rd_prev)
            rises <= rises + 1;
        rd_prev <= mon_rd;
        if (tx_valid && tx_ready && !abort && rst_n)
            got.push_back(tx_data);
        if (stall_prev && tx_valid && (tx_data !== stall_data))
            stall_viol <= stall_viol + 1;
        stall_prev <= tx_valid && !tx_ready && !abort;
        stall_data <= tx_data;
    end

    function automatic logic [15:0] exp_word(input int i);
        logic [7:0] a;
        if (i == 0)
            return 16'h1ACF;
        if (i == 36)
            return 16'hC3BE;
        a = 8'h19 + 8'(i - 1);
        return {a, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_req();
        @(negedge clk);
        tel_req = 1'b1;
        @(posedge clk);
        #1;
        tel_req = 1'b0;
        e0 = cyc;
        base = got.size();
        rbase = rises;
    endtask

    task automatic run_to_done(input int req_at, input bit bp, output int kk, output int bn);
        kk = -1;
        bn = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bp)
                tx_ready = ($urandom_range(0, 9) < 3);
            tel_req = (req_at > 0) && (cyc - e0 == req_at);
            if (busy)
                bn++;
            if (done) begin
                kk = cyc - e0;
                break;
            end
        end
        tel_req = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        int n;
        n = got.size() - base;
        check({tag, "_count"}, n, N_WORDS);
        for (int i = 0; i < N_WORDS && i < n; i++)
            check({tag, "_word"}, got[base + i], exp_word(i));
        check({tag, "_rd_rises"}, rises - rbase, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tel_req  = 1'b0;
        abort    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", mon_rd, 0);
        check("rst_addr", mon_addr, 8'h19);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lost", req_lost, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame with ready always high
        start_req();
        check("head_valid", tx_valid, 1);
        check("head_data", tx_data, 16'h1ACF);
        check("head_rd", mon_rd, 1);
        check("head_busy", busy, 1);
        run_to_done(0, 1'b0, k, busy_n);
        check("basic_done_cycle", k, DONE_K);
        check("basic_busy_cycles", busy_n, DONE_K + 1);
        check_frame("basic");
        @(negedge clk);
        check("basic_after_busy", busy, 0);
        check("basic_after_done", done, 0);

        // Backpressure
        start_req();
        run_to_done(0, 1'b1, k, busy_n);
        check("bp_done_seen", (k > 0), 1);
        check_frame("bp");
        check("bp_stable", stall_viol, 0);

        // Request while busy
        start_req();
        run_to_done(20, 1'b0, k, busy_n);
        check("lost_flag", req_lost, 1);
        check("lost_done_cycle", k, DONE_K);
        check_frame("lost");
        @(negedge clk);
        check("lost_idle", busy, 0);

        // Abort during SEND at 0x25, coinciding with a handshake
        start_req();
        check("lost_cleared", req_lost, 0);
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_valid && mon_addr == 8'h25) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached", found, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid", tx_valid, 0);
        check("abort_rd", mon_rd, 0);
        check("abort_busy", busy, 0);
        check("abort_words", got.size() - base, 13);
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (done)
                done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", done_seen, 0);
        start_req();
        run_to_done(0, 1'b0, k, busy_n);
        check("post_abort_done_cycle", k, DONE_K);
        check_frame("post_abort");

        // Asynchronous reset while in FETCH
        start_req();
        @(negedge clk);
        @(negedge clk);
        check("fetch_rd", mon_rd, 1);
        check("fetch_valid", tx_valid, 0);
        rst_n = 1'b0;
        #1;
        check("arst_rd", mon_rd, 0);
        check("arst_addr", mon_addr, 8'h19);
        check("arst_valid", tx_valid, 0);
        check("arst_data", tx_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_stays_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
